// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO result registers.
// Operations run for a fixed number of busy cycles and then write HI/LO together.
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO complete in the accepting edge
// RUN   | multiply/divide in flight, cnt counts remaining cycles
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic                 sgn, a_neg, b_neg, div_zero, res_we;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod;
  logic [WIDTH-1:0]     mag_a, mag_b, uq, ur, quo, rem, res_hi, res_lo;

  // One multiplier and one unsigned divider serve both signed and unsigned ops;
  // signed division works on magnitudes, which also wraps MIN/-1 to MIN.
  always_comb begin
    sgn      = ~op_q[0];
    ext_a    = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b    = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod     = ext_a * ext_b;
    a_neg    = sgn & a_q[WIDTH-1];
    b_neg    = sgn & b_q[WIDTH-1];
    mag_a    = a_neg ? -a_q : a_q;
    mag_b    = b_neg ? -b_q : b_q;
    div_zero = (b_q == '0);
    uq       = div_zero ? '0 : mag_a / mag_b;
    ur       = div_zero ? '0 : mag_a % mag_b;
    quo      = (a_neg ^ b_neg) ? -uq : uq;
    rem      = a_neg ? -ur : ur;
    if (op_q[1]) begin
      res_hi = rem;
      res_lo = quo;
      res_we = ~div_zero;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      res_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op[1:0];
                cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state <= RUN;
                busy  <= 1'b1;
              end
              3'd4:    HI <= A;
              3'd5:    LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt <= CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (res_we) begin
              HI <= res_hi;
              LO <= res_lo;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table with a scoreboard queue,
// plus hand sequences for start-while-busy, mid-operation reset and an 8-bit build.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8;
  logic [7:0]  hi8, lo8;

  md_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .HI(hi), .LO(lo)
  );

  md_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .HI(hi8), .LO(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  vec_t        vecs[15];
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int busy_len(input logic [2:0] o);
    if (o <= 3'd1) return MC;
    if (o <= 3'd3) return DC;
    return 0;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   n;
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    sb.push_back('{hi: v.hi, lo: v.lo, n: busy_len(v.op)});
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk($sformatf("v%0d_hold_hi", idx), hi, hi_m);
      chk($sformatf("v%0d_hold_lo", idx), lo, lo_m);
      n++;
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d_busy_cycles", idx), n, e.n);
    chk($sformatf("v%0d_hi", idx), hi, e.hi);
    chk($sformatf("v%0d_lo", idx), lo, e.lo);
    hi_m = e.hi;
    lo_m = e.lo;
  endtask

  initial begin
    int n;
    vecs[0]  = '{3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000};
    vecs[1]  = '{3'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h12345678};
    vecs[2]  = '{3'd3, 32'h00000005, 32'h0,        32'h12345678, 32'h12345678};
    vecs[3]  = '{3'd0, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[4]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5]  = '{3'd3, 32'hFFFFFFF9, 32'h2,        32'h00000001, 32'h7FFFFFFC};
    vecs[6]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{3'd2, 32'h00000064, 32'h0,        32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{3'd1, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[12] = '{3'd6, 32'hDEADBEEF, 32'h1,        32'h00000001, 32'h00000000};
    vecs[13] = '{3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vecs[14] = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy8", busy8, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // MTLO issued every cycle while a MULTU is in flight must be ignored
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    op = 3'd5; a = 32'hAAAA0000;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("ign_busy_cycles", n, MC);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd15);
    @(posedge clk); #1;
    chk("ign_lo_after", lo, 32'd15);

    // Reset between edges in the middle of a DIV aborts it
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    start = 1'b1; op = 3'd4; a = 32'h55;
    @(posedge clk); #1;
    chk("rst_start_ignored", hi, 0);
    start = 1'b0;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("postrst_busy", busy, 0);
    chk("postrst_hi", hi, 0);
    chk("postrst_lo", lo, 0);

    // 8-bit build, single-cycle multiply
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("w8_busy_on", busy8, 1);
    @(posedge clk); #1;
    chk("w8_busy_off", busy8, 0);
    chk("w8_hi", hi8, 8'hFE);
    chk("w8_lo", lo8, 8'h01);

    @(negedge clk);
    start8 = 1'b1; op8 = 3'd2; a8 = 8'h80; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (busy8 === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("w8_div_cycles", n, 3);
    chk("w8_div_hi", hi8, 8'h00);
    chk("w8_div_lo", lo8, 8'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result-register width in bits (legal values 4..64).
REQ-002 SHALL provide parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles (legal values 1 or more).
REQ-003 SHALL provide parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles (legal values 1 or more).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request strobe, sampled each rising edge.
REQ-007 SHALL have port op  input  3  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-008 SHALL have port A  input  WIDTH  first operand (multiplicand or dividend; MTHI/MTLO source).
REQ-009 SHALL have port B  input  WIDTH  second operand (multiplier or divisor).
REQ-010 SHALL have port busy  output  1  high while a multiply or divide is in flight.
REQ-011 SHALL have port HI  output  WIDTH  HI register (product upper half or remainder).
REQ-012 SHALL have port LO  output  WIDTH  LO register (product lower half or quotient).

Function
REQ-013 SHALL implement a two-state FSM (IDLE, RUN) plus a down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-014 SHALL accept a request only when start=1 and state=IDLE; in RUN, start and op are ignored.
REQ-015 SHALL, on an accepted op 0-3 at edge k, capture operands and op, enter RUN, and load the counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
REQ-016 SHALL assert busy, a registered output, high exactly over cycles k+1 .. k+N, where N is the loaded cycle count.
REQ-017 SHALL write HI/LO at edge k+N; at that same edge it SHALL return to IDLE so busy=0 and the new HI/LO are visible together.
REQ-018 SHALL allow a new request at edge k+N+1 or later, giving back-to-back throughput of one operation per N+1 cycles.
REQ-019 SHALL leave HI and LO unchanged during RUN until edge k+N.
REQ-020 SHALL, for MULT, form the 2*WIDTH-bit two's-complement product of A and B; for MULTU, the unsigned product; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-021 SHALL, for DIV, produce a signed quotient truncated toward zero in LO and a remainder in HI carrying the dividend's sign; for DIVU, the unsigned quotient and remainder.
REQ-022 SHALL, for DIV of the most-negative value by -1, give LO = most-negative value and HI = 0 (wrap, no trap).
REQ-023 SHALL, when the divisor is zero (op 2/3), still run DIV_CYCLES busy cycles and leave HI/LO unchanged at completion.
REQ-024 SHALL, on accepted MTHI (op 4) or MTLO (op 5) at edge k, load A into HI or LO at edge k, without asserting busy or entering RUN.
REQ-025 SHALL treat accepted op 6 or 7 as a no-op with no state change.
REQ-026 SHALL drive all outputs directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while reset=1, force state=IDLE, counter=0, busy=0, HI=0 and LO=0 immediately, independent of clk.
REQ-028 SHALL, on reset during RUN, abort the operation with no late HI/LO write after reset deasserts.
REQ-029 SHALL ignore start on any edge at which reset is high.

Verification
REQ-030 SHALL be checked with MULT, A=0xFFFFFFFE (-2), B=3, start at edge 0 -> busy=1 on cycles 1-5, at edge 5 HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
REQ-031 SHALL be checked with DIV, A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-032 SHALL be checked with DIVU, B=0, HI=LO=0x12345678 preloaded via MTHI/MTLO -> busy for 10 cycles, HI/LO still 0x12345678.
REQ-033 SHALL be checked with start+MTLO A=0xAAAA0000 issued while busy from a MULTU -> ignored; LO equals the MULTU result only.
REQ-034 SHALL be checked with reset asserted at cycle 3 of a DIV, mid-cycle between edges -> busy, HI, LO =0 at once; no update after release.
REQ-035 SHALL be checked with WIDTH=8, MULT_CYCLES=1, MULTU 0xFF*0xFF -> busy for one cycle, then HI=0xFE, LO=0x01.
